// File: rtl/leta_pkg.sv
// Shared types and the quadrature step decoder for the leta_quad trackball interface.
package leta_pkg;

    typedef logic [1:0] quad_state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2,
        DIR_ERR  = 2'd3
    } quad_dir_t;

    // Position of a state along the forward cycle 00->01->11->10 (Gray to binary).
    function automatic logic [1:0] quad_pos(input quad_state_t s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    function automatic quad_dir_t quad_decode(input quad_state_t prev,
                                              input quad_state_t cur,
                                              input logic        resoln);
        logic [1:0] step;
        quad_dir_t  dir;
        step = quad_pos(cur) - quad_pos(prev);
        case (step)
            2'd0:    dir = DIR_NONE;
            2'd1:    dir = DIR_UP;
            2'd3:    dir = DIR_DOWN;
            default: dir = DIR_ERR;
        endcase
        // In 1x mode only arrivals at 00 count; illegal jumps are flagged in both modes.
        return (!resoln && (dir != DIR_ERR) && (cur != 2'b00)) ? DIR_NONE : dir;
    endfunction

endpackage

// File: rtl/leta_quad_chan.sv
// One quadrature channel: input synchroniser, previous-state register, decode,
// wrapping up/down counter and sticky illegal-transition flag.
module leta_quad_chan
    import leta_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CK,
    input  logic             rst_b,
    input  logic             a,
    input  logic             b,
    input  logic             resoln,
    input  logic             prime_done,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    quad_state_t            prev_q;
    quad_state_t            cur_s;
    quad_dir_t              dir_s;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   err_q;
    logic                   err_d;

    assign cur_s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign dir_s = quad_decode(prev_q, cur_s, resoln);

    // Next counter / error state; nothing moves until priming has loaded prev.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (prime_done) begin
            case (dir_s)
                DIR_UP:   cnt_d = cnt_q + CNT_W'(1);
                DIR_DOWN: cnt_d = cnt_q - CNT_W'(1);
                DIR_ERR:  err_d = 1'b1;
                default:  cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // prev tracks s every cycle, so the last priming cycle leaves it primed.
    always_ff @(posedge CK or negedge rst_b) begin
        if (!rst_b) begin
            a_sync_q <= {SYNC_STAGES{1'b0}};
            b_sync_q <= {SYNC_STAGES{1'b0}};
            prev_q   <= 2'b00;
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b};
            prev_q   <= cur_s;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign cnt = cnt_q;
    assign err = err_q;

endmodule

// File: rtl/leta_quad.sv
// leta_quad top: NUM_CH quadrature channels, shared priming counter, coherent
// read snapshot registers and the tristate CPU read bus.
module leta_quad
    import leta_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    localparam int AD_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CK,
    input  logic              rst_b,
    input  logic [NUM_CH-1:0] quad_a,
    input  logic [NUM_CH-1:0] quad_b,
    input  logic              CS,
    input  logic [AD_W-1:0]   AD,
    input  logic              TEST,
    input  logic              RESOLN,
    output wire  [CNT_W-1:0]  DB,
    output logic [NUM_CH-1:0] err
);

    localparam int PRIME_LAST = SYNC_STAGES + 1;
    localparam int PRIME_W    = $clog2(SYNC_STAGES + 2);

    logic [PRIME_W-1:0] prime_q;
    logic               prime_done_s;
    logic [CNT_W-1:0]   cnt_s  [NUM_CH];
    logic [CNT_W-1:0]   hold_q [NUM_CH];
    logic [CNT_W-1:0]   rd_s;
    logic [CNT_W-1:0]   db_s;

    assign prime_done_s = (prime_q == PRIME_W'(PRIME_LAST));

    // Priming counter: sync chain fill plus one cycle to load prev.
    always_ff @(posedge CK or negedge rst_b) begin
        if (!rst_b) begin
            prime_q <= {PRIME_W{1'b0}};
        end else if (!prime_done_s) begin
            prime_q <= prime_q + PRIME_W'(1);
        end else begin
            prime_q <= prime_q;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        leta_quad_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .CK         (CK),
            .rst_b      (rst_b),
            .a          (quad_a[ch]),
            .b          (quad_b[ch]),
            .resoln     (RESOLN),
            .prime_done (prime_done_s),
            .cnt        (cnt_s[ch]),
            .err        (err[ch])
        );
    end

    // Snapshot: all holds track cnt while deselected and freeze together under CS=0.
    always_ff @(posedge CK or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= CS ? cnt_s[i] : hold_q[i];
        end
    end

    // Channel read mux; addresses beyond NUM_CH read as zero.
    always_comb begin
        rd_s = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(AD) == i) begin
                rd_s = hold_q[i];
            end else begin
                rd_s = rd_s;
            end
        end
    end

    // TEST overrides the channel data.
    always_comb begin
        db_s = {CNT_W{1'b0}};
        if (TEST) begin
            db_s = {CNT_W{1'b1}};
        end else begin
            db_s = rd_s;
        end
    end

    assign DB = CS ? {CNT_W{1'bz}} : db_s;

endmodule

// File: tb/tb_leta_quad.sv
// Self-checking bench for leta_quad: directed scenarios plus a random walk,
// checked against a position-based behavioural model of each channel.
module tb_leta_quad;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic           CK     = 1'b0;
    logic           rst_b  = 1'b0;
    logic           CS     = 1'b1;
    logic           TEST   = 1'b0;
    logic           RESOLN = 1'b1;
    logic [1:0]     AD     = 2'd0;
    logic [NCH-1:0] quad_a = '0;
    logic [NCH-1:0] quad_b = '0;
    wire  [W-1:0]   db4;
    wire  [W-1:0]   db3;
    logic [NCH-1:0] err4;
    logic [2:0]     err3;

    int             vectors     = 0;
    int             miscompares = 0;
    int             pos  [NCH];
    logic [W-1:0]   mcnt [NCH];
    logic [NCH-1:0] merr;

    always #5 CK = ~CK;

    leta_quad #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .CK(CK), .rst_b(rst_b), .quad_a(quad_a), .quad_b(quad_b), .CS(CS),
        .AD(AD), .TEST(TEST), .RESOLN(RESOLN), .DB(db4), .err(err4)
    );

    leta_quad #(.NUM_CH(3), .CNT_W(8), .SYNC_STAGES(2)) dut3 (
        .CK(CK), .rst_b(rst_b), .quad_a(quad_a[2:0]), .quad_b(quad_b[2:0]), .CS(CS),
        .AD(AD), .TEST(TEST), .RESOLN(RESOLN), .DB(db3), .err(err3)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: positions along the forward cycle; counts follow from position deltas.
    task automatic move(input int ch, input int np);
        int d;
        d = (np - pos[ch] + 4) % 4;
        if (d == 2) merr[ch] = 1'b1;
        else if (d == 1 && (RESOLN || np == 0)) mcnt[ch] = mcnt[ch] + 8'd1;
        else if (d == 3 && (RESOLN || np == 0)) mcnt[ch] = mcnt[ch] - 8'd1;
        pos[ch]    = np;
        quad_a[ch] = np[1];
        quad_b[ch] = np[1] ^ np[0];
    endtask

    task automatic step(input int ch, input int np, input int n);
        @(negedge CK);
        move(ch, np);
        repeat (n) @(posedge CK);
    endtask

    task automatic settle();
        repeat (4) @(posedge CK);
    endtask

    task automatic do_reset(input int p);
        @(negedge CK);
        rst_b = 1'b0;
        CS    = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            pos[c] = p; mcnt[c] = 8'd0;
            quad_a[c] = p[1]; quad_b[c] = p[1] ^ p[0];
        end
        merr = '0;
        repeat (2) @(negedge CK);
        rst_b = 1'b1;
        repeat (5) @(posedge CK);
    endtask

    task automatic rd(input int ad, input string tag);
        logic [W-1:0] e3;
        @(negedge CK);
        CS = 1'b0;
        AD = 2'(ad);
        #1;
        check({tag, "_db"}, db4, mcnt[ad]);
        e3 = (ad < 3) ? mcnt[ad] : 8'h00;
        check({tag, "_db3"}, db3, e3);
        CS = 1'b1;
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) rd(c, tag);
        check({tag, "_err"}, {4'h0, err4}, {4'h0, merr});
        check({tag, "_err3"}, {5'h00, err3}, {5'h00, merr[2:0]});
    endtask

    initial begin
        logic [W-1:0] snap;
        logic [W-1:0] hiz;
        hiz = 8'hzz;

        // Reset with inputs at 11: priming must absorb that level.
        do_reset(2);
        check_all("reset11");

        // Reset mid-operation at 00, then 4x counting on ch1.
        do_reset(0);
        RESOLN = 1'b1;
        for (int k = 1; k <= 4; k++) step(1, k % 4, 4);
        settle();
        rd(1, "ch1_fwd4");
        check("ch1_fwd4_lit", mcnt[1], 8'h04);
        for (int k = 1; k <= 5; k++) step(1, (8 - k) % 4, 4);
        settle();
        rd(1, "ch1_rev5");
        check("ch1_rev5_lit", mcnt[1], 8'hFF);

        // 1x mode on ch2: one cycle, then 256 more to wrap.
        RESOLN = 1'b0;
        for (int k = 1; k <= 4; k++) step(2, k % 4, 2);
        settle();
        rd(2, "ch2_1x");
        check("ch2_1x_lit", mcnt[2], 8'h01);
        for (int k = 0; k < 1024; k++) step(2, (k + 1) % 4, 1);
        settle();
        rd(2, "ch2_wrap");
        check("ch2_wrap_lit", mcnt[2], 8'h01);

        // Illegal jump on ch3, then legal steps still count; err is sticky.
        RESOLN = 1'b1;
        step(3, 2, 2);
        settle();
        check("ch3_err", {4'h0, err4}, 8'h08);
        rd(3, "ch3_jump");
        step(3, 3, 2);
        step(3, 0, 2);
        settle();
        rd(3, "ch3_after");
        check("ch3_after_lit", mcnt[3], 8'h02);
        check("ch3_err_sticky", {4'h0, err4}, 8'h08);

        // Coherent snapshot on ch0.
        step(0, 1, 2);
        settle();
        @(negedge CK);
        CS = 1'b0; AD = 2'd0;
        #1;
        snap = db4;
        check("snap_base", snap, mcnt[0]);
        for (int k = 2; k <= 4; k++) step(0, k % 4, 2);
        settle();
        #1;
        check("snap_frozen", db4, snap);
        @(negedge CK);
        CS = 1'b1;
        @(negedge CK);
        CS = 1'b0;
        #1;
        check("snap_update", db4, snap + 8'd3);
        check("snap_model", db4, mcnt[0]);
        CS = 1'b1;
        #1;
        check("hiz", db4, hiz);
        CS = 1'b0; TEST = 1'b1;
        #1;
        check("test_ff", db4, 8'hFF);
        check("test_ff3", db3, 8'hFF);
        TEST = 1'b0; CS = 1'b1;
        rd(3, "ad_oob");

        // Random walk across all channels with random mode and TEST.
        for (int it = 0; it < 240; it++) begin
            if (it == 120) do_reset($urandom_range(0, 3));
            @(negedge CK);
            RESOLN = 1'($urandom_range(0, 1));
            TEST   = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) begin
                int r;
                r = $urandom_range(0, 31);
                if (r < 10)       move(c, (pos[c] + 1) % 4);
                else if (r < 20)  move(c, (pos[c] + 3) % 4);
                else if (r == 31) move(c, (pos[c] + 2) % 4);
            end
            repeat (3) @(posedge CK);
            if (it % 20 == 19) begin
                TEST = 1'b0;
                settle();
                check_all("rand");
            end
        end

        // Final reset clears everything.
        do_reset(1);
        check_all("reset_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/leta_quad.md
# leta_quad

Parametrised quadrature trackball decoder, the synthesizable successor to the LETA bus-functional model. NUM_CH independent quadrature inputs are synchronised and decoded into up/down counters. Counter values are read on an 8-bit-style CPU data bus through chip select and address lines, with the same TEST and RESOLN controls as the LETA part. Adds illegal-transition detection, coherent multi-channel read snapshots and configurable counter width.

## Interface
- NUM_CH, 4, number of quadrature channels (1..16)
- CNT_W, 8, counter and data-bus width
- SYNC_STAGES, 2, synchroniser flops per A/B input (>=2)
- CK  input  1  system clock; all state on rising edge
- rst_b  input  1  reset, asynchronous, active-low
- quad_a  input  NUM_CH  phase A per channel, asynchronous
- quad_b  input  NUM_CH  phase B per channel, asynchronous
- CS  input  1  chip select, active-low, synchronous to CK
- AD  input  $clog2(NUM_CH) (min 1)  channel select for read
- TEST  input  1  1 = force DB to all ones
- RESOLN  input  1  1 = count every edge (4x); 0 = one count per quadrature cycle (1x)
- DB  output  CNT_W  read data; high-Z when CS=1
- err  output  NUM_CH  sticky illegal-transition flag per channel

## Operation
- Per channel: A and B each pass through SYNC_STAGES flops. Decoded state s = {A_sync, B_sync}; prev holds s from the previous cycle.
- Forward sequence 00→01→11→10→00 gives direction UP. The reverse gives DOWN. s == prev gives NONE. Both bits changing gives ERR.
- RESOLN=1: UP increments, DOWN decrements, on every qualifying transition.
- RESOLN=0: only transitions whose new state is 00 count; 01→00 is DOWN, 10→00 is UP.
- Arithmetic is modulo 2^CNT_W. 0 DOWN → all ones; all ones UP → 0. No saturation.
- ERR: counter unchanged, err[ch] set. err clears only on reset.
- Priming: after reset, decode is disabled for SYNC_STAGES+1 cycles.
  - The final priming cycle loads prev from s without counting.
  - Input level at reset release is therefore never counted or flagged.
- Snapshot: hold[ch] copies cnt[ch] on every CK edge where CS=1. While CS=0 all hold registers freeze, giving a coherent read of all channels.
- Counters keep counting while frozen.
- DB output selection:
  - CS=1 → high-Z.
  - CS=0, TEST=1 → all ones.
  - CS=0, TEST=0, AD<NUM_CH → hold[AD].
  - CS=0, TEST=0, AD>=NUM_CH → 0.
  - DB is combinational from these inputs and registers.
- Reset values: sync flops, prev, cnt, hold and err are all 0. DB is high-Z if CS=1, otherwise per the rules above.

## Timing
- An input edge sampled at CK edge n reaches s at edge n+SYNC_STAGES−1. cnt updates at edge n+SYNC_STAGES.
- hold reflects cnt one edge later, if CS=1.
- Read latency is zero cycles from AD/CS/TEST to DB (combinational).
- A CS fall between edges freezes hold at its value from the last edge with CS=1.
- Counting and the hold update are concurrent on the same edge: hold gets the pre-update cnt.
- Reset asserted mid-operation clears all state immediately; priming restarts on release.
- TEST has no effect on counting or err.

## Structure
- Package leta_pkg:
  - typedef quad_state_t (2-bit).
  - enum quad_dir_t {DIR_NONE, DIR_UP, DIR_DOWN, DIR_ERR}.
  - function quad_decode(prev, cur, resoln) returning quad_dir_t.
- Sub-module leta_quad_chan, generated NUM_CH times.
  - Contains synchroniser, prev register, decode, counter and err flag.
  - Ports: CK, rst_b, a, b, resoln, prime_done, cnt, err.
- Top level holds:
  - Shared priming counter (drives prime_done).
  - hold array.
  - DB mux with tristate.

## Test plan
- Reset with quad inputs at 11, release, wait 5 cycles. Expect cnt=0, err=0 (priming absorbs the level). Read AD=0, CS=0 → DB=0x00.
- Ch1, RESOLN=1: drive 4 forward steps 00→01→11→10→00, each held 4 cycles. Read AD=1 → 0x04. Then 5 reverse steps → 0xFF.
- RESOLN=0: one full forward cycle on ch2 → ch2 reads 0x01. Repeat 256 full cycles → wraps back to 0x01.
- Ch3: jump 00→11 in one step → err[3]=1, count unchanged. Legal steps afterwards count normally; err stays 1 until rst_b.
- Coherent snapshot:
  - Hold CS=0 while ch0 gets 3 forward steps → DB on AD=0 unchanged.
  - Raise CS for one edge, lower it → DB shows +3.
  - CS=1 → DB high-Z. TEST=1 with CS=0 → 0xFF. AD=NUM_CH (NUM_CH=3 build) → 0x00.
